// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and AXI constants for the instruction prefetch unit
package ifu_pkg;

   // Instruction/PC width of the queue entries (fixed 32 in this generation)
   localparam int IFU_XLEN = 32;

   localparam logic [1:0] FETCH_ID       = 2'd0;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef struct packed {
      logic [IFU_XLEN-1:0] inst;
      logic [IFU_XLEN-1:0] pc;
      logic                err;
   } fetch_entry_t;

   typedef enum logic {
      AR_IDLE,
      AR_REQ
   } ar_state_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// rtl/ifu_fetch_fifo.sv - synchronous instruction queue with flush and occupancy count
module ifu_fetch_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic         head_valid,
   output logic [AW:0]  count
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push    = push && (count != FULL);
   assign do_pop     = pop && (count != '0);
   assign head_valid = (count != '0);
   // Empty queue presents an all-zero head so outputs read 0 out of reset
   assign head       = head_valid ? mem[rd_ptr] : '0;

   // Pointer and occupancy tracking; a flush empties the queue at once
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Entry storage; contents only matter while counted as valid
   always_ff @(posedge clk) begin
      if (do_push && !(rst || clear)) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - multi-outstanding AXI4 instruction prefetcher with redirect and stale-drop
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter int                  ADDR_WIDTH      = 32,
   parameter int                  DATA_WIDTH      = 32,
   parameter int                  ID_WIDTH        = 2,
   parameter int                  MAX_OUTSTANDING = 4,
   parameter int                  FIFO_DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC      = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
   output logic                  inst_valid_o,
   output logic [DATA_WIDTH-1:0] inst_o,
   output logic [ADDR_WIDTH-1:0] inst_addr_o,
   output logic                  inst_err_o,
   input  logic                  inst_ready_i,
   output logic [ID_WIDTH-1:0]   M_AXI_ARID,
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]            M_AXI_ARLEN,
   output logic [2:0]            M_AXI_ARSIZE,
   output logic [1:0]            M_AXI_ARBURST,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [ID_WIDTH-1:0]   M_AXI_RID,
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RLAST,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);

   localparam int         FAW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);
   localparam logic [7:0] DEPTH_C = 8'(FIFO_DEPTH);

   ar_state_t             state, state_n;
   logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_n;
   logic [ADDR_WIDTH-1:0] resp_pc;
   logic [ADDR_WIDTH-1:0] ar_addr, ar_addr_n;
   logic [3:0]            inflight, inflight_n;
   logic [3:0]            drop_cnt, drop_n;
   logic                  pend_stale, pend_stale_n;
   logic [FAW:0]          fifo_cnt, fifo_cnt_n;
   logic [7:0]            credit;
   logic                  ar_fire, r_fire, r_drop, held, issue;
   logic                  push, pop;
   fetch_entry_t          push_data, head;
   logic                  head_valid;
   logic                  unused_rbits;

   assign unused_rbits  = &{1'b0, M_AXI_RID, M_AXI_RLAST};

   assign M_AXI_ARID    = ID_WIDTH'(FETCH_ID);
   assign M_AXI_ARADDR  = ar_addr;
   assign M_AXI_ARLEN   = 8'd0;
   assign M_AXI_ARSIZE  = AXI_SIZE_4B;
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign M_AXI_ARVALID = (state == AR_REQ);
   assign M_AXI_RREADY  = 1'b1;

   assign ar_fire = (state == AR_REQ) && M_AXI_ARREADY;
   assign held    = (state == AR_REQ) && !M_AXI_ARREADY;
   // A beat with nothing outstanding is ignored so inflight cannot wrap
   assign r_fire  = M_AXI_RVALID && (inflight != 4'd0);
   assign r_drop  = r_fire && (drop_cnt != 4'd0);
   assign push    = r_fire && !r_drop && !redirect_i;
   assign pop     = inst_valid_o && inst_ready_i && !redirect_i;

   assign push_data.inst = IFU_XLEN'(M_AXI_RDATA);
   assign push_data.pc   = IFU_XLEN'(resp_pc);
   assign push_data.err  = (M_AXI_RRESP != AXI_RESP_OKAY);

   assign inst_valid_o = head_valid;
   assign inst_o       = DATA_WIDTH'(head.inst);
   assign inst_addr_o  = ADDR_WIDTH'(head.pc);
   assign inst_err_o   = head.err;

   ifu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (redirect_i),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .head       (head),
      .head_valid (head_valid),
      .count      (fifo_cnt)
   );

   // Post-edge counter values; issue credit is judged on these so ARs can go back-to-back
   always_comb begin
      inflight_n   = inflight + 4'(ar_fire) - 4'(r_fire);
      drop_n       = drop_cnt - 4'(r_drop) + 4'(ar_fire && pend_stale);
      pend_stale_n = pend_stale && !ar_fire;
      fetch_pc_n   = (ar_fire && !pend_stale) ? fetch_pc + ADDR_WIDTH'(4) : fetch_pc;
      fifo_cnt_n   = fifo_cnt + (FAW+1)'(push) - (FAW+1)'(pop);
      if (redirect_i) begin
         // Everything still in flight after this edge belongs to the old path
         drop_n       = inflight_n;
         pend_stale_n = held;
         fetch_pc_n   = redirect_addr_i;
         fifo_cnt_n   = '0;
      end
      credit = 8'(fifo_cnt_n) + 8'(inflight_n) - 8'(drop_n);
      issue  = !held && (inflight_n < MAX_OUT) && (credit < DEPTH_C);
   end

   // AR next-state: hold until accepted, otherwise raise whenever credit allows
   always_comb begin
      state_n   = AR_IDLE;
      ar_addr_n = ar_addr;
      if (held) begin
         state_n = AR_REQ;
      end else if (issue) begin
         state_n   = AR_REQ;
         ar_addr_n = fetch_pc_n;
      end
   end

   // AR state and address registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= AR_IDLE;
         ar_addr <= RESET_PC;
      end else begin
         state   <= state_n;
         ar_addr <= ar_addr_n;
      end
   end

   // Outstanding/stale bookkeeping and the two PCs
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight   <= '0;
         drop_cnt   <= '0;
         pend_stale <= 1'b0;
         fetch_pc   <= RESET_PC;
         resp_pc    <= RESET_PC;
      end else begin
         inflight   <= inflight_n;
         drop_cnt   <= drop_n;
         pend_stale <= pend_stale_n;
         fetch_pc   <= fetch_pc_n;
         if (redirect_i)  resp_pc <= redirect_addr_i;
         else if (push)   resp_pc <= resp_pc + ADDR_WIDTH'(4);
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - scoreboard bench for ifu_prefetch with a 1-cycle AXI read slave
module tb_ifu_prefetch;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        inst_err;
   logic        inst_ready = 1'b0;
   logic [1:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [1:0]  rid = '0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rlast = 1'b1;
   logic        rvalid = 1'b0;
   logic        rready;

   exp_t        exp_q[$];
   logic [31:0] exp_ar[$];
   logic [31:0] rq[$];
   int          deliv_cyc[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          ar_count = 0;
   int          ar_budget = 0;
   bit          r_en = 1'b1;
   bit          ar_hs = 1'b0;
   logic [31:0] ar_hs_addr = '0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;

   ifu_prefetch dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_i      (redirect),
      .redirect_addr_i (redirect_addr),
      .inst_valid_o    (inst_valid),
      .inst_o          (inst),
      .inst_addr_o     (inst_addr),
      .inst_err_o      (inst_err),
      .inst_ready_i    (inst_ready),
      .M_AXI_ARID      (arid),
      .M_AXI_ARADDR    (araddr),
      .M_AXI_ARLEN     (arlen),
      .M_AXI_ARSIZE    (arsize),
      .M_AXI_ARBURST   (arburst),
      .M_AXI_ARVALID   (arvalid),
      .M_AXI_ARREADY   (arready),
      .M_AXI_RID       (rid),
      .M_AXI_RDATA     (rdata),
      .M_AXI_RRESP     (rresp),
      .M_AXI_RLAST     (rlast),
      .M_AXI_RVALID    (rvalid),
      .M_AXI_RREADY    (rready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign arready = (ar_budget != 0);

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_ar(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_ar.push_back(base + 32'(4 * i));
   endtask

   task automatic push_inst(input logic [31:0] base, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc   = base + 32'(4 * i);
         e.inst = rdata_of(e.pc);
         e.err  = (e.pc == err_addr);
         exp_q.push_back(e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || exp_ar.size() != 0) && t < 200) begin
         @(posedge clk);
         t++;
      end
      if (t >= 200) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0", exp_q.size(), exp_ar.size());
      end
      tick(3);
   endtask

   task automatic wait_budget();
      int t = 0;
      while (ar_budget != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (t >= 100) begin
         n_vec++;
         n_err++;
         $display("FAIL ar_timeout: got budget %0d expected 0", ar_budget);
      end
      #2;
   endtask

   // Monitor: AR handshakes against expected address queue, deliveries against expected entries
   always @(negedge clk) begin
      exp_t e;
      ar_hs      = arvalid && arready;
      ar_hs_addr = araddr;
      if (ar_hs) begin
         ar_count++;
         if (exp_ar.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL ar_unexpected: got %h expected none", araddr);
         end else begin
            check("araddr", araddr, exp_ar.pop_front());
         end
      end
      if (inst_valid && inst_ready && !redirect) begin
         deliv_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL inst_unexpected: got pc %h expected none", inst_addr);
         end else begin
            e = exp_q.pop_front();
            check("inst_addr", inst_addr, e.pc);
            check("inst_data", inst, e.inst);
            check("inst_err", 32'(inst_err), 32'(e.err));
         end
      end
   end

   // Read slave: each accepted AR returns one beat starting the following cycle
   always @(posedge clk) begin
      logic [31:0] a;
      #1;
      if (ar_hs) begin
         rq.push_back(ar_hs_addr);
         if (ar_budget > 0) ar_budget--;
      end
      if (r_en && rq.size() != 0) begin
         a      = rq.pop_front();
         rvalid = 1'b1;
         rdata  = rdata_of(a);
         rresp  = (a == err_addr) ? 2'b10 : 2'b00;
      end else begin
         rvalid = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      tick(3);
      @(negedge clk);
      check("rst_arvalid", 32'(arvalid), 0);
      check("rst_araddr", araddr, 32'h8000_0000);
      check("rst_inst_valid", 32'(inst_valid), 0);
      check("rst_inst", inst, 0);
      check("rst_inst_addr", inst_addr, 0);
      check("rst_inst_err", 32'(inst_err), 0);
      check("rst_rready", 32'(rready), 1);
      check("rst_arsize", 32'(arsize), 2);
      check("rst_arburst", 32'(arburst), 1);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("arvalid_first_cycle", 32'(arvalid), 0);
      @(negedge clk);
      check("arvalid_second_cycle", 32'(arvalid), 1);
      check("araddr_first", araddr, 32'h8000_0000);

      // Streaming from RESET_PC
      tick(1);
      push_ar(32'h8000_0000, 8);
      push_inst(32'h8000_0000, 8);
      deliv_cyc.delete();
      inst_ready = 1'b1;
      ar_budget  = 8;
      drain();
      check("stream_count", 32'(deliv_cyc.size()), 8);
      if (deliv_cyc.size() == 8) check("stream_span", 32'(deliv_cyc[7] - deliv_cyc[0]), 7);

      // Credit limit with decode stalled
      inst_ready = 1'b0;
      push_ar(32'h8000_0020, 6);
      push_inst(32'h8000_0020, 6);
      base      = ar_count;
      ar_budget = 6;
      tick(15);
      @(negedge clk);
      check("credit_ar_count", 32'(ar_count - base), 4);
      check("credit_arvalid", 32'(arvalid), 0);
      check("credit_inst_valid", 32'(inst_valid), 1);
      tick(1);
      inst_ready = 1'b1;
      drain();

      // Three reads in flight plus a held AR, then redirect
      r_en = 1'b0;
      push_ar(32'h8000_0038, 3);
      ar_budget = 3;
      wait_budget();
      tick(2);
      redirect      = 1'b1;
      redirect_addr = 32'h8000_1000;
      tick(1);
      redirect = 1'b0;
      @(negedge clk);
      check("redir_arvalid_held", 32'(arvalid), 1);
      check("redir_araddr_held", araddr, 32'h8000_0044);
      check("redir_inst_valid", 32'(inst_valid), 0);
      tick(2);
      @(negedge clk);
      check("redir_araddr_still", araddr, 32'h8000_0044);
      tick(1);
      push_ar(32'h8000_0044, 1);
      push_ar(32'h8000_1000, 3);
      push_inst(32'h8000_1000, 3);
      r_en      = 1'b1;
      ar_budget = 4;
      drain();

      // Error response on one PC
      err_addr      = 32'h8000_0008;
      redirect      = 1'b1;
      redirect_addr = 32'h8000_0000;
      tick(1);
      redirect = 1'b0;
      push_ar(32'h8000_100C, 1);
      push_ar(32'h8000_0000, 5);
      push_inst(32'h8000_0000, 5);
      ar_budget = 6;
      drain();

      // Redirect coinciding with an R beat and a pop
      push_ar(32'h8000_0014, 2);
      ar_budget = 2;
      tick(1);
      tick(1);
      redirect      = 1'b1;
      redirect_addr = 32'h8000_2000;
      @(negedge clk);
      check("coinc_rvalid", 32'(rvalid), 1);
      check("coinc_inst_valid", 32'(inst_valid), 1);
      tick(1);
      redirect = 1'b0;
      @(negedge clk);
      check("coinc_flushed", 32'(inst_valid), 0);
      tick(1);
      push_ar(32'h8000_001C, 1);
      push_ar(32'h8000_2000, 2);
      push_inst(32'h8000_2000, 2);
      ar_budget = 3;
      drain();

      check("left_inst", 32'(exp_q.size()), 0);
      check("left_ar", 32'(exp_ar.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
